// File: rtl/hyper_slave.sv
// HyperBus memory slave: oversamples dram_ck on clk, 16-bit word array plus ID0/CR0 registers.
// Build option: define HYPER_SLAVE_DOUBLE_LATENCY_EN for fixed 2x initial latency (flagged on RWDS in CA).
module hyper_slave #(
    parameter int          ADDR_W   = 10,
    parameter int          LATENCY  = 6,
    parameter logic [15:0] CR0_INIT = 16'h8F1F,
    parameter logic [15:0] ID0_VAL  = 16'h0C81
) (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       dram_cs_l,
    input  logic       dram_rst_l,
    input  logic       dram_ck,
    input  logic [7:0] dram_dq_in,
    output logic [7:0] dram_dq_out,
    output logic       dram_dq_oe_l,
    input  logic       dram_rwds_in,
    output logic       dram_rwds_out,
    output logic       dram_rwds_oe_l
);

`ifdef HYPER_SLAVE_DOUBLE_LATENCY_EN
    localparam int   LAT_MULT = 2;
    localparam logic LAT_FLAG = 1'b1;
`else
    localparam int   LAT_MULT = 1;
    localparam logic LAT_FLAG = 1'b0;
`endif
    // LATENCY is expected to be at least 1; the counter spans 2*N byte events.
    localparam int                LAT_EV   = 2 * LAT_MULT * LATENCY;
    localparam int                CNT_W    = (LAT_EV > 2) ? $clog2(LAT_EV) : 1;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LAT_EV - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_CA, ST_LAT, ST_WR, ST_RD} state_t;

    state_t            state_r;
    logic              ck_q_r;
    logic              cs_q_r;
    logic [47:0]       ca_r;
    logic [2:0]        ca_cnt_r;
    logic [CNT_W-1:0]  lat_cnt_r;
    logic              half_r;
    logic              is_read_r;
    logic              is_reg_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        wr_hi_r;
    logic              wr_mask_hi_r;
    logic [15:0]       cr0_r;
    logic [7:0]        dq_out_r;
    logic              dq_oe_l_r;
    logic              rwds_out_r;
    logic              rwds_oe_l_r;
    logic [15:0]       mem_r [0:(2**ADDR_W)-1];

    logic              srst_s;
    logic              byte_ev_s;
    logic [47:0]       ca_next_s;
    logic [ADDR_W-1:0] ca_addr_s;
    logic [15:0]       rd_word_s;
    logic              mem_we_s;
    logic              unused_s;

    function automatic logic [15:0] merge_word(input logic [15:0] old_w, input logic [7:0] hi,
                                               input logic [7:0] lo, input logic mask_hi,
                                               input logic mask_lo);
        return {(mask_hi ? old_w[15:8] : hi), (mask_lo ? old_w[7:0] : lo)};
    endfunction

    assign srst_s    = ~dram_rst_l;
    assign byte_ev_s = (dram_ck != ck_q_r) && !dram_cs_l;
    assign ca_next_s = {ca_r[39:0], dram_dq_in};
    assign ca_addr_s = ADDR_W'({ca_next_s[44:16], ca_next_s[2:0]});
    assign rd_word_s = is_reg_r ? (addr_r[0] ? cr0_r : ID0_VAL) : mem_r[addr_r];
    assign mem_we_s  = reset_l && dram_rst_l && (state_r == ST_WR) && byte_ev_s && half_r && !is_reg_r;
    // Burst type and the reserved CA bits carry no meaning for this device.
    assign unused_s  = ^{ca_r[47:40], ca_next_s[45], ca_next_s[15:3]};

    assign dram_dq_out    = dq_out_r;
    assign dram_dq_oe_l   = dq_oe_l_r;
    assign dram_rwds_out  = rwds_out_r;
    assign dram_rwds_oe_l = rwds_oe_l_r;

    // Array write port; contents deliberately survive both resets.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[addr_r] <= merge_word(mem_r[addr_r], wr_hi_r, dram_dq_in, wr_mask_hi_r, dram_rwds_in);
        end
    end

    // Transaction FSM with edge detect, CA capture, latency count and registered bus outputs.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_r      <= ST_IDLE;
            ck_q_r       <= 1'b0;
            cs_q_r       <= 1'b0;
            ca_r         <= 48'h0;
            ca_cnt_r     <= 3'd0;
            lat_cnt_r    <= '0;
            half_r       <= 1'b0;
            is_read_r    <= 1'b0;
            is_reg_r     <= 1'b0;
            addr_r       <= '0;
            wr_hi_r      <= 8'h00;
            wr_mask_hi_r <= 1'b0;
            cr0_r        <= CR0_INIT;
            dq_out_r     <= 8'h00;
            dq_oe_l_r    <= 1'b1;
            rwds_out_r   <= 1'b0;
            rwds_oe_l_r  <= 1'b1;
        end else if (srst_s) begin
            state_r      <= ST_IDLE;
            ck_q_r       <= 1'b0;
            cs_q_r       <= 1'b0;
            ca_r         <= 48'h0;
            ca_cnt_r     <= 3'd0;
            lat_cnt_r    <= '0;
            half_r       <= 1'b0;
            is_read_r    <= 1'b0;
            is_reg_r     <= 1'b0;
            addr_r       <= '0;
            wr_hi_r      <= 8'h00;
            wr_mask_hi_r <= 1'b0;
            cr0_r        <= CR0_INIT;
            dq_out_r     <= 8'h00;
            dq_oe_l_r    <= 1'b1;
            rwds_out_r   <= 1'b0;
            rwds_oe_l_r  <= 1'b1;
        end else if (dram_cs_l) begin
            // A partially received write word is dropped by clearing the byte phase.
            state_r     <= ST_IDLE;
            ck_q_r      <= dram_ck;
            cs_q_r      <= 1'b1;
            ca_cnt_r    <= 3'd0;
            lat_cnt_r   <= '0;
            half_r      <= 1'b0;
            dq_oe_l_r   <= 1'b1;
            rwds_oe_l_r <= 1'b1;
        end else begin
            ck_q_r <= dram_ck;
            cs_q_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_CA: begin
                    // Only a seen falling edge of dram_cs_l starts a transaction.
                    if ((state_r == ST_CA) || cs_q_r) begin
                        state_r     <= ST_CA;
                        rwds_oe_l_r <= 1'b0;
                        rwds_out_r  <= LAT_FLAG;
                        if (byte_ev_s) begin
                            ca_r <= ca_next_s;
                            if (ca_cnt_r == 3'd5) begin
                                ca_cnt_r    <= 3'd0;
                                is_read_r   <= ca_next_s[47];
                                is_reg_r    <= ca_next_s[46];
                                addr_r      <= ca_addr_s;
                                half_r      <= 1'b0;
                                lat_cnt_r   <= '0;
                                rwds_oe_l_r <= 1'b1;
                                rwds_out_r  <= 1'b0;
                                if (!ca_next_s[47] && ca_next_s[46]) begin
                                    state_r <= ST_WR;
                                end else begin
                                    state_r <= ST_LAT;
                                end
                            end else begin
                                ca_cnt_r <= ca_cnt_r + 3'd1;
                            end
                        end
                    end
                end
                ST_LAT: begin
                    if (byte_ev_s) begin
                        if (lat_cnt_r == LAT_LAST) begin
                            lat_cnt_r <= '0;
                            half_r    <= 1'b0;
                            if (is_read_r) begin
                                state_r     <= ST_RD;
                                dq_oe_l_r   <= 1'b0;
                                rwds_oe_l_r <= 1'b0;
                                rwds_out_r  <= 1'b0;
                            end else begin
                                state_r <= ST_WR;
                            end
                        end else begin
                            lat_cnt_r <= lat_cnt_r + 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (byte_ev_s) begin
                        if (!half_r) begin
                            wr_hi_r      <= dram_dq_in;
                            wr_mask_hi_r <= dram_rwds_in;
                            half_r       <= 1'b1;
                        end else begin
                            half_r <= 1'b0;
                            if (is_reg_r) begin
                                if (addr_r[0]) begin
                                    cr0_r <= merge_word(cr0_r, wr_hi_r, dram_dq_in, wr_mask_hi_r, dram_rwds_in);
                                end
                            end else begin
                                addr_r <= addr_r + 1'b1;
                            end
                        end
                    end
                end
                ST_RD: begin
                    dq_oe_l_r   <= 1'b0;
                    rwds_oe_l_r <= 1'b0;
                    if (byte_ev_s) begin
                        dq_out_r   <= half_r ? rd_word_s[7:0] : rd_word_s[15:8];
                        rwds_out_r <= dram_ck;
                        half_r     <= ~half_r;
                        if (half_r && !is_reg_r) begin
                            addr_r <= addr_r + 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
